// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM states, effect slot indices and slot search for the fx scheduler
package audio_pkg;
  localparam int RESOLUTION = 32;
  localparam int FX_CLIP = 0;
  localparam int FX_ECHO = 1;
  localparam int FX_CHORUS = 2;
  localparam int FX_REVERB = 3;
  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT, NEXT, COMMIT} state_t;
  // Lowest set bit of mask at or above from; 32 when none exists
  function automatic int next_slot(input logic [31:0] mask, input int from);
    int r;
    r = 32;
    for (int i = 31; i >= 0; i--) if (i >= from && mask[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchroniser plus hold counter for one asynchronous switch bit
module sw_debounce #(
  parameter int DEBOUNCE = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      db <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/fx_chain_scheduler.sv
// fx_chain_scheduler: per-frame sequencing of L then R samples through a shared effect engine
module fx_chain_scheduler
  import audio_pkg::*;
#(
  parameter int RESOLUTION = audio_pkg::RESOLUTION,
  parameter int NUM_FX = 4,
  parameter int DEBOUNCE = 1024,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_strobe,
  input  logic [RESOLUTION-1:0]     data_L_in,
  input  logic [RESOLUTION-1:0]     data_R_in,
  input  logic [NUM_FX-1:0]         sw_fx,
  output logic                      fx_start,
  output logic [$clog2(NUM_FX)-1:0] fx_sel,
  output logic [RESOLUTION-1:0]     fx_data,
  input  logic                      fx_done,
  input  logic [RESOLUTION-1:0]     fx_result,
  output logic [RESOLUTION-1:0]     data_L_out,
  output logic [RESOLUTION-1:0]     data_R_out,
  output logic                      out_valid,
  output logic [NUM_FX-1:0]         fx_active,
  output logic                      overrun,
  output logic                      timeout_err
);
  localparam int SW = $clog2(NUM_FX);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [NUM_FX-1:0] sw_db;
  for (genvar g = 0; g < NUM_FX; g++) begin : g_db
    sw_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (.clk(clk), .reset_n(reset_n), .sw(sw_fx[g]), .db(sw_db[g]));
  end
  state_t state;
  logic ch;
  logic [RESOLUTION-1:0] cap_l, cap_r, acc, res_l;
  logic [TW-1:0] wcnt;
  int first_slot, after_slot;
  always_comb begin
    first_slot = next_slot(32'(fx_active), 0);
    after_slot = next_slot(32'(fx_active), int'(fx_sel) + 1);
  end
  // Request outputs are loaded on entry to ISSUE so fx_start is high exactly during ISSUE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ch <= 1'b0;
      cap_l <= '0;
      cap_r <= '0;
      acc <= '0;
      res_l <= '0;
      wcnt <= '0;
      fx_start <= 1'b0;
      fx_sel <= '0;
      fx_data <= '0;
      data_L_out <= '0;
      data_R_out <= '0;
      out_valid <= 1'b0;
      fx_active <= '0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      fx_start <= 1'b0;
      out_valid <= 1'b0;
      if (frame_strobe && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (frame_strobe) begin
          cap_l <= data_L_in;
          cap_r <= data_R_in;
          fx_active <= sw_db;
          state <= LATCH;
        end
        LATCH: begin
          ch <= 1'b0;
          acc <= cap_l;
          if (first_slot < NUM_FX) begin
            fx_start <= 1'b1;
            fx_sel <= SW'(first_slot);
            fx_data <= cap_l;
            state <= ISSUE;
          end else state <= NEXT;
        end
        ISSUE: begin
          wcnt <= '0;
          state <= WAIT;
        end
        WAIT: if (fx_done) begin
          acc <= fx_result;
          if (after_slot < NUM_FX) begin
            fx_start <= 1'b1;
            fx_sel <= SW'(after_slot);
            fx_data <= fx_result;
            state <= ISSUE;
          end else state <= NEXT;
        end else if (wcnt == TW'(TIMEOUT - 1)) begin
          acc <= fx_data;
          timeout_err <= 1'b1;
          state <= NEXT;
        end else wcnt <= wcnt + TW'(1);
        NEXT: if (!ch) begin
          res_l <= acc;
          ch <= 1'b1;
          acc <= cap_r;
          if (first_slot < NUM_FX) begin
            fx_start <= 1'b1;
            fx_sel <= SW'(first_slot);
            fx_data <= cap_r;
            state <= ISSUE;
          end
        end else begin
          data_L_out <= res_l;
          data_R_out <= acc;
          out_valid <= 1'b1;
          state <= COMMIT;
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fx_chain_scheduler.sv
// tb_fx_chain_scheduler: scoreboard bench with a 3-cycle data+1 engine model
module tb_fx_chain_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_strobe = 1'b0;
  logic [31:0] data_L_in = '0, data_R_in = '0;
  logic [3:0] sw_fx = '0;
  logic fx_start;
  logic [1:0] fx_sel;
  logic [31:0] fx_data;
  logic fx_done = 1'b0;
  logic [31:0] fx_result = '0;
  logic [31:0] data_L_out, data_R_out;
  logic out_valid;
  logic [3:0] fx_active;
  logic overrun, timeout_err;
  int checks = 0, errors = 0;
  int starts = 0, outs = 0;
  logic [63:0] exp_q[$];
  logic [1:0] sel_log[$];
  logic eng_en = 1'b0;
  int eng_cnt = 0;
  logic [31:0] eng_val = '0;

  fx_chain_scheduler dut (
    .clk(clk), .reset_n(reset_n), .frame_strobe(frame_strobe),
    .data_L_in(data_L_in), .data_R_in(data_R_in), .sw_fx(sw_fx),
    .fx_start(fx_start), .fx_sel(fx_sel), .fx_data(fx_data),
    .fx_done(fx_done), .fx_result(fx_result),
    .data_L_out(data_L_out), .data_R_out(data_R_out), .out_valid(out_valid),
    .fx_active(fx_active), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // engine: result = operand + 1, fx_done three cycles after the fx_start cycle
  always @(posedge clk) begin
    fx_done <= 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        fx_done <= 1'b1;
        fx_result <= eng_val + 32'd1;
      end
    end else if (fx_start && eng_en) begin
      eng_cnt <= 2;
      eng_val <= fx_data;
    end
  end

  always @(negedge clk) begin
    if (fx_start) begin
      starts++;
      sel_log.push_back(fx_sel);
    end
    if (out_valid) begin
      outs++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got L=%h R=%h want no commit", data_L_out, data_R_out);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({data_L_out, data_R_out} !== e)
          begin errors++; $display("FAIL out_data got L=%h R=%h want L=%h R=%h", data_L_out, data_R_out, e[63:32], e[31:0]); end
      end
    end
  end

  task automatic run_frame(input logic [31:0] l, r, el, er, output int lat);
    exp_q.push_back({el, er});
    @(posedge clk); #1;
    data_L_in = l; data_R_in = r; frame_strobe = 1'b1;
    @(posedge clk); #1;
    frame_strobe = 1'b0;
    lat = -1;
    for (int j = 1; j <= 700; j++) begin
      @(negedge clk);
      if (out_valid) begin lat = j; break; end
    end
    if (lat < 0) begin checks++; errors++; $display("FAIL frame_wait got no out_valid want one within 700 cycles"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fx_start, fx_sel, fx_data, data_L_out, data_R_out, out_valid, fx_active, overrun, timeout_err} !== '0)
      begin errors++; $display("FAIL reset_outputs got nonzero want all zero"); end
    reset_n = 1'b1;
  endtask

  task automatic test_no_fx;
    int lat, s0;
    s0 = starts;
    sw_fx = 4'b0000;
    run_frame(32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL no_fx_latency got %0d want 4", lat); end
    checks++;
    if (starts - s0 !== 0) begin errors++; $display("FAIL no_fx_starts got %0d want 0", starts - s0); end
    checks++;
    if (fx_active !== 4'b0000) begin errors++; $display("FAIL no_fx_active got %b want 0000", fx_active); end
  endtask

  task automatic test_debounce;
    int lat;
    eng_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sw_fx = (k % 2 == 1) ? 4'b0010 : 4'b0000;
      run_frame(32'h100 + k, 32'h200 + k, 32'h100 + k, 32'h200 + k, lat);
      checks++;
      if (fx_active[1] !== 1'b0) begin errors++; $display("FAIL debounce_toggle k=%0d got %b want 0", k, fx_active[1]); end
      repeat (90) @(posedge clk);
    end
    repeat (800) @(posedge clk);
    run_frame(32'h300, 32'h400, 32'h300, 32'h400, lat);
    checks++;
    if (fx_active !== 4'b0000) begin errors++; $display("FAIL debounce_early got %b want 0000", fx_active); end
    repeat (150) @(posedge clk);
    run_frame(32'h500, 32'h600, 32'h501, 32'h601, lat);
    checks++;
    if (fx_active !== 4'b0010) begin errors++; $display("FAIL debounce_held got %b want 0010", fx_active); end
  endtask

  task automatic test_chain;
    int lat, s0;
    sw_fx = 4'b0101;
    repeat (1040) @(posedge clk);
    sel_log.delete();
    s0 = starts;
    run_frame(32'h0000_00FE, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0001, lat);
    checks++;
    if (lat !== 20) begin errors++; $display("FAIL chain_latency got %0d want 20", lat); end
    checks++;
    if (starts - s0 !== 4) begin errors++; $display("FAIL chain_starts got %0d want 4", starts - s0); end
    checks++;
    if (sel_log.size() != 4 || sel_log[0] !== 2'd0 || sel_log[1] !== 2'd2 || sel_log[2] !== 2'd0 || sel_log[3] !== 2'd2)
      begin errors++; $display("FAIL chain_sel got %p want 0,2,0,2", sel_log); end
    checks++;
    if (fx_active !== 4'b0101) begin errors++; $display("FAIL chain_active got %b want 0101", fx_active); end
  endtask

  task automatic test_timeout;
    int lat, s0;
    eng_en = 1'b0;
    sw_fx = 4'b0001;
    repeat (1040) @(posedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pre got %b want 0", timeout_err); end
    s0 = starts;
    run_frame(32'hCAFE_0001, 32'hBEEF_0002, 32'hCAFE_0001, 32'hBEEF_0002, lat);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b want 1", timeout_err); end
    checks++;
    if (lat < 510 || lat > 530) begin errors++; $display("FAIL timeout_latency got %0d want 510..530", lat); end
    checks++;
    if (starts - s0 !== 2) begin errors++; $display("FAIL timeout_starts got %0d want 2", starts - s0); end
    checks++;
    if (dut.state !== audio_pkg::IDLE) begin errors++; $display("FAIL timeout_idle got %0d want IDLE", dut.state); end
    eng_en = 1'b1;
  endtask

  task automatic test_overrun;
    int o0;
    bit seen;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre got %b want 0", overrun); end
    o0 = outs;
    exp_q.push_back({32'h0000_1001, 32'h0000_2001});
    @(posedge clk); #1;
    data_L_in = 32'h1000; data_R_in = 32'h2000; frame_strobe = 1'b1;
    @(posedge clk); #1;
    frame_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    data_L_in = 32'hDEAD; data_R_in = 32'hBEEF; frame_strobe = 1'b1;
    @(posedge clk); #1;
    frame_strobe = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin checks++; errors++; $display("FAIL overrun_wait got no out_valid want one within 50 cycles"); end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
    checks++;
    if (outs - o0 !== 1) begin errors++; $display("FAIL overrun_commits got %0d want 1", outs - o0); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(posedge clk); #1;
    data_L_in = 32'h7777; data_R_in = 32'h8888; frame_strobe = 1'b1;
    @(posedge clk); #1;
    frame_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({fx_start, fx_sel, fx_data, data_L_out, data_R_out, out_valid, fx_active, overrun, timeout_err} !== '0)
      begin errors++; $display("FAIL reset_mid_outputs got nonzero want all zero"); end
    sw_fx = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    run_frame(32'h1111_2222, 32'h3333_4444, 32'h1111_2222, 32'h3333_4444, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL reset_mid_latency got %0d want 4", lat); end
    checks++;
    if (overrun !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_mid_sticky got %b%b want 00", overrun, timeout_err); end
  endtask

  initial begin
    test_reset();
    test_no_fx();
    test_debounce();
    test_chain();
    test_timeout();
    test_overrun();
    test_reset_mid();
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
